// File: rtl/sha1_padder.sv
`default_nettype none
// ============================================================================
// sha1_padder: packs big-endian 32-bit message words into 512-bit SHA-1 blocks
// and appends the 0x80 marker, zero fill and 64-bit big-endian bit length.
// Revision: 1.0
// ============================================================================
module sha1_padder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
);
    typedef enum logic [1:0] {
        S_FILL       = 2'd0,
        S_EMIT       = 2'd1,
        S_EMIT_EXTRA = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [63:0] count_q;
    logic        first_q;
    logic        pad_pending_q;
    logic        marker_pending_q;
    logic        in_ready_q;
    logic        blk_valid_q;
    logic        blk_first_q;
    logic        blk_last_q;
    logic [31:0] words_q [16];

    logic        in_fire_d;
    logic        blk_fire_d;
    logic [2:0]  nb_d;
    logic        full_d;
    logic [63:0] count_d;
    logic [63:0] bitlen_d;
    logic [31:0] keep_mask_d;
    logic [31:0] marker_d;
    logic [31:0] last_word_d;
    logic [4:0]  p_d;
    logic        len_here_d;

    always_comb begin
        in_fire_d   = in_valid & in_ready_q;
        blk_fire_d  = blk_valid_q & blk_ready;
        // Non-last words always carry 4 bytes; out-of-range counts saturate at 4.
        nb_d        = (!in_last || in_nbytes >= 3'd4) ? 3'd4 : in_nbytes;
        full_d      = (nb_d == 3'd4);
        count_d     = count_q + {61'd0, nb_d};
        bitlen_d    = {count_d[60:0], 3'b000};
        keep_mask_d = ~(32'hFFFF_FFFF >> {nb_d, 3'b000});
        marker_d    = full_d ? 32'h0 : (32'h8000_0000 >> {nb_d, 3'b000});
        last_word_d = (in_data & keep_mask_d) | marker_d;
        p_d         = {1'b0, idx_q} + {4'd0, full_d};
        len_here_d  = (p_d <= 5'd13);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_FILL;
            idx_q            <= '0;
            count_q          <= '0;
            first_q          <= 1'b1;
            pad_pending_q    <= 1'b0;
            marker_pending_q <= 1'b0;
            in_ready_q       <= 1'b1;
            blk_valid_q      <= 1'b0;
            blk_first_q      <= 1'b0;
            blk_last_q       <= 1'b0;
            for (int j = 0; j < 16; j++) words_q[j] <= '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (in_fire_d) begin
                        count_q <= count_d;
                        if (!in_last) begin
                            words_q[idx_q] <= in_data;
                            idx_q          <= idx_q + 4'd1;
                            if (idx_q == 4'd15) begin
                                state_q     <= S_EMIT;
                                in_ready_q  <= 1'b0;
                                blk_valid_q <= 1'b1;
                                blk_first_q <= first_q;
                                blk_last_q  <= 1'b0;
                            end
                        end else begin
                            // p is the word holding the marker; 16 means it spills over.
                            for (int j = 0; j < 16; j++) begin
                                if (5'(j) == {1'b0, idx_q})
                                    words_q[j] <= last_word_d;
                                else if (5'(j) > {1'b0, idx_q}) begin
                                    if (len_here_d && j == 14)
                                        words_q[j] <= bitlen_d[63:32];
                                    else if (len_here_d && j == 15)
                                        words_q[j] <= bitlen_d[31:0];
                                    else if (full_d && 5'(j) == p_d)
                                        words_q[j] <= 32'h8000_0000;
                                    else
                                        words_q[j] <= '0;
                                end
                            end
                            state_q          <= S_EMIT;
                            in_ready_q       <= 1'b0;
                            blk_valid_q      <= 1'b1;
                            blk_first_q      <= first_q;
                            blk_last_q       <= len_here_d;
                            pad_pending_q    <= ~len_here_d;
                            marker_pending_q <= (p_d == 5'd16);
                        end
                    end
                end
                S_EMIT: begin
                    if (blk_fire_d) begin
                        first_q <= 1'b0;
                        if (pad_pending_q) begin
                            for (int j = 0; j < 16; j++) words_q[j] <= '0;
                            words_q[0]  <= marker_pending_q ? 32'h8000_0000 : 32'h0;
                            words_q[14] <= {count_q[60:29]};
                            words_q[15] <= {count_q[28:0], 3'b000};
                            state_q     <= S_EMIT_EXTRA;
                            blk_first_q <= 1'b0;
                            blk_last_q  <= 1'b1;
                        end else begin
                            if (blk_last_q) begin
                                count_q <= '0;
                                first_q <= 1'b1;
                            end
                            idx_q       <= '0;
                            state_q     <= S_FILL;
                            in_ready_q  <= 1'b1;
                            blk_valid_q <= 1'b0;
                            blk_first_q <= 1'b0;
                            blk_last_q  <= 1'b0;
                        end
                    end
                end
                S_EMIT_EXTRA: begin
                    if (blk_fire_d) begin
                        count_q          <= '0;
                        idx_q            <= '0;
                        pad_pending_q    <= 1'b0;
                        marker_pending_q <= 1'b0;
                        first_q          <= 1'b1;
                        state_q          <= S_FILL;
                        in_ready_q       <= 1'b1;
                        blk_valid_q      <= 1'b0;
                        blk_first_q      <= 1'b0;
                        blk_last_q       <= 1'b0;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_pack
        assign blk_data[511-32*g -: 32] = words_q[g];
    end

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;

endmodule
`default_nettype wire

// File: tb/tb_sha1_padder.sv
`default_nettype none
// ============================================================================
// tb_sha1_padder: random messages checked against a byte-level FIPS 180-4
// padding model; directed cases for the corner lengths and reset behaviour.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sha1_padder;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         blk_ready = 1'b0;
    logic [31:0]  in_data = '0;
    logic [2:0]   in_nbytes = '0;
    logic         in_ready, blk_valid, blk_first, blk_last;
    logic [511:0] blk_data;

    int n_cmp = 0;
    int n_err = 0;

    sha1_padder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    logic [511:0] exp_data_q [$];
    bit           exp_first_q[$];
    bit           exp_last_q [$];
    bit           exp_extra_q[$];
    logic [31:0]  drv_data_q [$];
    bit           drv_last_q [$];
    logic [2:0]   drv_nb_q   [$];
    bit           drv_emit_q [$];
    logic [511:0] got_q      [$];
    byte unsigned msg_buf    [$];

    // Model: pad the byte string per FIPS 180-4, slice into 64-byte blocks.
    task automatic add_msg(input bit tail_empty);
        byte unsigned pad[$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        logic [31:0]  w;
        int len, nblk, nfull, rem;
        bit use_tail, is_last;
        len      = msg_buf.size();
        nfull    = len / 4;
        rem      = len % 4;
        use_tail = (rem != 0) || tail_empty || (len == 0);
        pad = msg_buf;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bitlen = 64'(len) * 64'd8;
        for (int k = 7; k >= 0; k--) pad.push_back(bitlen[8*k +: 8]);
        nblk = pad.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < 64; k++) blk[511-8*k -: 8] = pad[64*b+k];
            exp_data_q.push_back(blk);
            exp_first_q.push_back(b == 0);
            exp_last_q.push_back(b == nblk-1);
            exp_extra_q.push_back((b == nblk-1) && (64*(nblk-1) >= len) &&
                                  !(use_tail && (len % 64 == 0)));
        end
        for (int i = 0; i < nfull; i++) begin
            w = {msg_buf[4*i], msg_buf[4*i+1], msg_buf[4*i+2], msg_buf[4*i+3]};
            is_last = !use_tail && (i == nfull-1);
            drv_data_q.push_back(w);
            drv_last_q.push_back(is_last);
            drv_nb_q.push_back(is_last ? 3'd4 : 3'($urandom_range(0, 7)));
            drv_emit_q.push_back(is_last || (i % 16 == 15));
        end
        if (use_tail) begin
            w = $urandom;
            for (int b = 0; b < rem; b++) w[31-8*b -: 8] = msg_buf[4*nfull+b];
            drv_data_q.push_back(w);
            drv_last_q.push_back(1'b1);
            drv_nb_q.push_back(3'(rem));
            drv_emit_q.push_back(1'b1);
        end
    endtask

    task automatic rand_msg(input int len);
        msg_buf.delete();
        for (int i = 0; i < len; i++) msg_buf.push_back(8'($urandom));
    endtask

    // stall < 0 picks a random 0..4 cycle back-pressure per block.
    task automatic run(input int stall, input bit gaps);
        int nblk, dwait, mwait, ns;
        bit acc, emit;
        logic [511:0] cap;
        logic cf, cl;
        nblk = exp_data_q.size();
        got_q.delete();
        fork
            begin
                @(negedge clk);
                while (drv_data_q.size() > 0) begin
                    if (gaps && $urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(negedge clk);
                    end
                    in_valid  = 1'b1;
                    in_data   = drv_data_q[0];
                    in_last   = drv_last_q[0];
                    in_nbytes = drv_nb_q[0];
                    emit = drv_emit_q[0];
                    acc = 1'b0;
                    dwait = 0;
                    while (!acc && dwait < 300) begin
                        acc = in_ready;
                        @(negedge clk);
                        dwait++;
                    end
                    void'(drv_data_q.pop_front());
                    void'(drv_last_q.pop_front());
                    void'(drv_nb_q.pop_front());
                    void'(drv_emit_q.pop_front());
                    if (!acc) begin
                        n_cmp++; n_err++;
                        $display("FAIL in_accept_timeout: word not accepted after %0d cycles (want acceptance)", dwait);
                        drv_data_q.delete(); drv_last_q.delete();
                        drv_nb_q.delete(); drv_emit_q.delete();
                        break;
                    end
                    if (emit) begin
                        n_cmp++;
                        if (blk_valid !== 1'b1) begin
                            n_err++;
                            $display("FAIL blk_latency: blk_valid=%b one cycle after block-closing word (want 1)", blk_valid);
                        end
                    end
                end
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            begin
                @(negedge clk);
                for (int b = 0; b < nblk; b++) begin
                    mwait = 0;
                    while (blk_valid !== 1'b1 && mwait < 400) begin
                        @(negedge clk);
                        mwait++;
                    end
                    if (blk_valid !== 1'b1) begin
                        n_cmp++; n_err++;
                        $display("FAIL blk_timeout: block %0d never valid (blk_valid=%b, want 1)", b, blk_valid);
                        break;
                    end
                    if (exp_extra_q[b]) begin
                        n_cmp++;
                        if (mwait != 0) begin
                            n_err++;
                            $display("FAIL extra_latency: pad block valid after %0d extra cycles (want 0)", mwait);
                        end
                    end
                    cap = blk_data; cf = blk_first; cl = blk_last;
                    got_q.push_back(cap);
                    n_cmp++;
                    if (cap !== exp_data_q[b]) begin
                        n_err++;
                        $display("FAIL blk_data[%0d]: got %h want %h", b, cap, exp_data_q[b]);
                    end
                    n_cmp++;
                    if (cf !== exp_first_q[b]) begin
                        n_err++;
                        $display("FAIL blk_first[%0d]: got %b want %b", b, cf, exp_first_q[b]);
                    end
                    n_cmp++;
                    if (cl !== exp_last_q[b]) begin
                        n_err++;
                        $display("FAIL blk_last[%0d]: got %b want %b", b, cl, exp_last_q[b]);
                    end
                    ns = (stall < 0) ? int'($urandom_range(0, 4)) : stall;
                    repeat (ns) begin
                        blk_ready = 1'b0;
                        @(negedge clk);
                        n_cmp++;
                        if (blk_valid !== 1'b1 || blk_data !== cap || in_ready !== 1'b0 ||
                            blk_first !== cf || blk_last !== cl) begin
                            n_err++;
                            $display("FAIL stall_hold[%0d]: valid=%b ready=%b data_same=%b first=%b last=%b (want 1 0 1 %b %b)",
                                     b, blk_valid, in_ready, blk_data === cap, blk_first, blk_last, cf, cl);
                        end
                    end
                    blk_ready = 1'b1;
                    @(negedge clk);
                    blk_ready = 1'b0;
                end
            end
        join
        exp_data_q.delete(); exp_first_q.delete();
        exp_last_q.delete(); exp_extra_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_first !== 1'b0 ||
            blk_last !== 1'b0 || blk_data !== '0) begin
            n_err++;
            $display("FAIL reset_state: in_ready=%b blk_valid=%b first=%b last=%b data_zero=%b (want 1 0 0 0 1)",
                     in_ready, blk_valid, blk_first, blk_last, blk_data === '0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b blk_valid=%b (want 1 0)", in_ready, blk_valid);
        end
    endtask

    task automatic test_abc();
        msg_buf.delete();
        msg_buf.push_back(8'h61); msg_buf.push_back(8'h62); msg_buf.push_back(8'h63);
        add_msg(1'b0);
        run(0, 1'b0);
        n_cmp++;
        if (got_q.size() != 1 || got_q[0][511:480] !== 32'h6162_6380 ||
            got_q[0][479:32] !== '0 || got_q[0][31:0] !== 32'h0000_0018) begin
            n_err++;
            $display("FAIL abc_words: nblk=%0d w0=%h w15=%h (want 1 61626380 00000018)",
                     got_q.size(), got_q.size() > 0 ? got_q[0][511:480] : 32'hx,
                     got_q.size() > 0 ? got_q[0][31:0] : 32'hx);
        end
    endtask

    task automatic test_empty();
        msg_buf.delete();
        add_msg(1'b1);
        run(1, 1'b0);
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== {32'h8000_0000, 480'd0}) begin
            n_err++;
            $display("FAIL empty_block: nblk=%0d w0=%h (want 1 80000000, rest zero)",
                     got_q.size(), got_q.size() > 0 ? got_q[0][511:480] : 32'hx);
        end
    endtask

    task automatic test_boundaries();
        int lens[9] = '{55, 56, 60, 63, 64, 65, 119, 120, 128};
        rand_msg(55); add_msg(1'b0); run(-1, 1'b0);
        n_cmp++;
        if (got_q.size() != 1 || got_q[0][71:64] !== 8'h80 || got_q[0][31:0] !== 32'h0000_01B8) begin
            n_err++;
            $display("FAIL len55: nblk=%0d w13lo=%h w15=%h (want 1 80 000001b8)", got_q.size(),
                     got_q.size() > 0 ? got_q[0][71:64] : 8'hx, got_q.size() > 0 ? got_q[0][31:0] : 32'hx);
        end
        rand_msg(56); add_msg(1'b0); run(-1, 1'b0);
        n_cmp++;
        if (got_q.size() != 2 || got_q[0][63:32] !== 32'h8000_0000 || got_q[0][31:0] !== 32'h0 ||
            got_q[1][31:0] !== 32'h0000_01C0) begin
            n_err++;
            $display("FAIL len56: nblk=%0d b0w14=%h b1w15=%h (want 2 80000000 000001c0)", got_q.size(),
                     got_q.size() > 0 ? got_q[0][63:32] : 32'hx, got_q.size() > 1 ? got_q[1][31:0] : 32'hx);
        end
        foreach (lens[i]) begin
            for (int t = 0; t < 2; t++) begin
                rand_msg(lens[i]);
                add_msg(t[0]);
            end
        end
        run(-1, 1'b1);
    endtask

    task automatic test_back_to_back();
        rand_msg(64); add_msg(1'b0);
        rand_msg(3);  add_msg(1'b0);
        run(5, 1'b0);
        n_cmp++;
        if (got_q.size() != 3 || got_q[1][511:480] !== 32'h8000_0000 || got_q[1][31:0] !== 32'h0000_0200) begin
            n_err++;
            $display("FAIL b2b_pad: nblk=%0d pad_w0=%h pad_w15=%h (want 3 80000000 00000200)", got_q.size(),
                     got_q.size() > 1 ? got_q[1][511:480] : 32'hx, got_q.size() > 1 ? got_q[1][31:0] : 32'hx);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            for (int m = 0; m < 3; m++) begin
                rand_msg($urandom_range(0, 150));
                add_msg(1'($urandom));
            end
            run(-1, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = $urandom; in_last = 1'b0; in_nbytes = 3'd4;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (blk_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_mid_noblock: blk_valid seen=%b after mid-message reset (want 0)", seen);
        end
        rand_msg(10); add_msg(1'b0);
        run(0, 1'b0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached (want completion)");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_boundaries();
        test_back_to_back();
        test_random();
        test_reset_mid();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_end: blk_valid=%b in_ready=%b (want 0 1)", blk_valid, in_ready);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
